// File: rtl/ins_judge.sv
// ins_judge -- instruction-phase responder for the NOT NOT game.
//
// When game_control pulses enable_instruction, this block draws a random
// instruction from a free-running LFSR. The instruction is a direction plus a
// negation depth. The block then captures the player's key press and release
// and judges the press against the NOT rule. It drives the correct and wrong
// flags and the running score that the feedback UI consumes.
//
// Ports:
//   clk                 in   1        system clock, rising edge
//   reset_n             in   1        asynchronous active-low reset
//   reset_ui            in   1        active-low synchronous clear of score
//   enable_instruction  in   1        1-cycle pulse: start a new round
//   STATE_ins           in   1        high while controller is in instruction states
//   user_input          in   6        key levels [0..5] = W A S D R L
//   reset_correct       in   1        active-low synchronous clear of correct
//   reset_wrong         in   1        active-low synchronous clear of wrong
//   ins_dir             out  3        instruction direction 0..5
//   ins_neg             out  2        negation depth 0..2
//   ins_valid           out  1        instruction fields hold a live round
//   correct             out  1        last judged round was correct
//   wrong               out  1        last judged round was wrong
//   judge_done          out  1        1-cycle pulse when a judgement registers
//   score               out  SCORE_W  saturating count of correct rounds
module ins_judge #(
  parameter logic [7:0] LFSR_SEED = 8'hA5,
  parameter int         SCORE_W   = 8
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               reset_ui,
  input  logic               enable_instruction,
  input  logic               STATE_ins,
  input  logic [5:0]         user_input,
  input  logic               reset_correct,
  input  logic               reset_wrong,
  output logic [2:0]         ins_dir,
  output logic [1:0]         ins_neg,
  output logic               ins_valid,
  output logic               correct,
  output logic               wrong,
  output logic               judge_done,
  output logic [SCORE_W-1:0] score
);

  // An all-zero seed would lock the LFSR, so it is replaced by 1.
  localparam logic [7:0]         SEED      = (LFSR_SEED == 8'h00) ? 8'h01 : LFSR_SEED;
  localparam logic [SCORE_W-1:0] SCORE_MAX = {SCORE_W{1'b1}};

  typedef enum logic [2:0] {IDLE, ARMED, HELD, EVAL, DONE} state_t;

  state_t             state_reg;
  logic [7:0]         lfsr_reg;
  logic [5:0]         key_acc_reg;
  logic [2:0]         ins_dir_reg;
  logic [1:0]         ins_neg_reg;
  logic               ins_valid_reg;
  logic               correct_reg;
  logic               wrong_reg;
  logic               judge_done_reg;
  logic [SCORE_W-1:0] score_reg;

  logic       lfsr_fb;
  logic [2:0] draw_dir;
  logic [1:0] draw_neg;
  logic [5:0] target;
  logic       key_onehot;
  logic       judge_ok;

  // Fibonacci LFSR, x^8+x^6+x^5+x^4+1, shifting toward the MSB.
  assign lfsr_fb = lfsr_reg[7] ^ lfsr_reg[5] ^ lfsr_reg[4] ^ lfsr_reg[3];

  // Fold the 3-bit field into 0..5, and fold negation depth 3 onto 1.
  assign draw_dir = (lfsr_reg[2:0] >= 3'd6) ? (lfsr_reg[2:0] - 3'd6) : lfsr_reg[2:0];
  assign draw_neg = (lfsr_reg[4:3] == 2'd3) ? 2'd1 : lfsr_reg[4:3];

  // Judge: even depth wants the named key, odd depth wants any other single
  // key. A chord (more than one key ever held) never counts as legal.
  assign target     = 6'b000001 << ins_dir_reg;
  assign key_onehot = (key_acc_reg != 6'd0) && ((key_acc_reg & (key_acc_reg - 6'd1)) == 6'd0);
  assign judge_ok   = ins_neg_reg[0] ? (key_onehot && (key_acc_reg != target))
                                     : (key_acc_reg == target);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lfsr_reg <= SEED;
    end else begin
      lfsr_reg <= {lfsr_reg[6:0], lfsr_fb};
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg      <= IDLE;
      key_acc_reg    <= 6'd0;
      ins_dir_reg    <= 3'd0;
      ins_neg_reg    <= 2'd0;
      ins_valid_reg  <= 1'b0;
      correct_reg    <= 1'b0;
      wrong_reg      <= 1'b0;
      judge_done_reg <= 1'b0;
      score_reg      <= '0;
    end else begin
      judge_done_reg <= 1'b0;
      // A new round may start from any state; this also drops any
      // half-captured key and any pending judgement.
      if (enable_instruction) begin
        state_reg     <= ARMED;
        ins_dir_reg   <= draw_dir;
        ins_neg_reg   <= draw_neg;
        ins_valid_reg <= 1'b1;
        key_acc_reg   <= 6'd0;
      end else begin
        case (state_reg)
          ARMED: begin
            if (!STATE_ins) begin
              state_reg     <= IDLE;
              ins_valid_reg <= 1'b0;
            end else if (|user_input) begin
              state_reg   <= HELD;
              key_acc_reg <= user_input;
            end
          end
          HELD: begin
            if (!STATE_ins) begin
              state_reg     <= IDLE;
              ins_valid_reg <= 1'b0;
            end else if (user_input == 6'd0) begin
              // The judgement registers on the same edge as the move to
              // EVAL, so the flags are visible for the whole EVAL cycle.
              state_reg      <= EVAL;
              judge_done_reg <= 1'b1;
              correct_reg    <= judge_ok;
              wrong_reg      <= !judge_ok;
              if (judge_ok && (score_reg != SCORE_MAX)) begin
                score_reg <= score_reg + SCORE_W'(1);
              end
            end else begin
              key_acc_reg <= key_acc_reg | user_input;
            end
          end
          EVAL:    state_reg <= DONE;
          default: state_reg <= state_reg;
        endcase
      end
      // The clears come last so that they beat a set on the same edge.
      if (!reset_correct) correct_reg <= 1'b0;
      if (!reset_wrong)   wrong_reg   <= 1'b0;
      if (!reset_ui)      score_reg   <= '0;
    end
  end

  assign ins_dir    = ins_dir_reg;
  assign ins_neg    = ins_neg_reg;
  assign ins_valid  = ins_valid_reg;
  assign correct    = correct_reg;
  assign wrong      = wrong_reg;
  assign judge_done = judge_done_reg;
  assign score      = score_reg;

endmodule
